// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, synchronizer depth and parity helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;

    localparam int STATE_IDLE      = 0;
    localparam int STATE_START     = 1;
    localparam int STATE_DATA_BASE = 2;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4
    } rx_phase_t;

    function automatic int state_parity(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int state_stop(input int data_width);
        return data_width + 3;
    endfunction

    // Non-zero when data bits, parity bit and the odd/even selector do not XOR to zero.
    function automatic logic parity_mismatch(input logic data_xor, input logic parity_bit,
                                             input logic odd_parity);
        return data_xor ^ parity_bit ^ odd_parity;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, payload/status out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int STATE_WIDTH = $clog2(DATA_WIDTH + 3);

    logic                   serial_in;
    logic [DATA_WIDTH-1:0]  received_data;
    logic                   data_is_valid;
    logic                   rx_error;
    logic [STATE_WIDTH-1:0] state;

    modport master (
        input  serial_in,
        output received_data,
        output data_is_valid,
        output rx_error,
        output state
    );

    modport slave (
        output serial_in,
        input  received_data,
        input  data_is_valid,
        input  rx_error,
        input  state
    );

endinterface

// File: rtl/uart_rx_synchronizer.sv
// Metastability chain for the asynchronous serial line; resets to the idle-high level.
module uart_rx_synchronizer
    import uart_pkg::*;
#(
    parameter int STAGES = NUMBER_OF_RX_SYNCHRONIZERS
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic [STAGES-1:0] sync_r;

    // Shift the line through the chain; reset to 1 so no false start edge appears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized line, mid-bit sampling, optional parity, one-cycle result pulses.
// Define UART_RX_FRAMING_ERROR_EN to reject frames whose stop bit samples low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int W  = INPUT_DATA_WIDTH;
    localparam int SW = $clog2(W + 3);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] HALF_BIT   = CW'(CLOCKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT   = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);
    localparam logic          ODD_PARITY = (PARITY_TYPE != 0) ? 1'b1 : 1'b0;
    localparam int            ST_PARITY  = state_parity(W);
    localparam int            ST_STOP    = state_stop(W);

    logic          line_s;
    logic          line_prev_r;
    rx_phase_t     phase_r, phase_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [BW-1:0] bit_cnt_r, bit_cnt_s;
    logic [W-1:0]  shift_r, shift_s;
    logic [W-1:0]  rx_data_r, rx_data_s;
    logic          bad_r, bad_s, frame_bad_s;
    logic          valid_r, valid_s;
    logic          err_r, err_s;
    logic [SW-1:0] state_r, state_s;

    uart_rx_synchronizer #(.STAGES(NUMBER_OF_RX_SYNCHRONIZERS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.serial_in),
        .dout  (line_s)
    );

    // Next-state, sampling and result logic; a start needs a high-to-low edge of the synchronized line.
    always_comb begin
        phase_s     = phase_r;
        cnt_s       = cnt_r + CW'(1);
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        bad_s       = bad_r;
        frame_bad_s = bad_r;
        rx_data_s   = rx_data_r;
        valid_s     = 1'b0;
        err_s       = 1'b0;
        case (phase_r)
            PH_IDLE: begin
                cnt_s = '0;
                if (line_prev_r && !line_s) begin
                    phase_s   = PH_START;
                    bit_cnt_s = '0;
                    bad_s     = 1'b0;
                end else begin
                    phase_s = PH_IDLE;
                end
            end
            PH_START: begin
                if (cnt_r == HALF_BIT) begin
                    cnt_s   = '0;
                    phase_s = line_s ? PH_IDLE : PH_DATA;
                end else begin
                    phase_s = PH_START;
                end
            end
            PH_DATA: begin
                if (cnt_r == FULL_BIT) begin
                    cnt_s   = '0;
                    shift_s = (W'(line_s) << (W - 1)) | (shift_r >> 1);
                    if (bit_cnt_r == LAST_BIT) begin
                        phase_s = (PARITY_ENABLED != 0) ? PH_PARITY : PH_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    phase_s = PH_DATA;
                end
            end
            PH_PARITY: begin
                if (cnt_r == FULL_BIT) begin
                    cnt_s   = '0;
                    bad_s   = bad_r | parity_mismatch(^shift_r, line_s, ODD_PARITY);
                    phase_s = PH_STOP;
                end else begin
                    phase_s = PH_PARITY;
                end
            end
            PH_STOP: begin
                if (cnt_r == FULL_BIT) begin
                    cnt_s   = '0;
                    phase_s = PH_IDLE;
`ifdef UART_RX_FRAMING_ERROR_EN
                    frame_bad_s = bad_r | ~line_s;
`else
                    frame_bad_s = bad_r;
`endif
                    if (frame_bad_s) begin
                        err_s = 1'b1;
                    end else begin
                        valid_s   = 1'b1;
                        rx_data_s = shift_r;
                    end
                end else begin
                    phase_s = PH_STOP;
                end
            end
            default: begin
                phase_s = PH_IDLE;
                cnt_s   = '0;
            end
        endcase

        case (phase_s)
            PH_IDLE:   state_s = SW'(STATE_IDLE);
            PH_START:  state_s = SW'(STATE_START);
            PH_DATA:   state_s = SW'(STATE_DATA_BASE) + SW'(bit_cnt_s);
            PH_PARITY: state_s = SW'(ST_PARITY);
            PH_STOP:   state_s = SW'(ST_STOP);
            default:   state_s = SW'(STATE_IDLE);
        endcase
    end

    // State and output registers; reset abandons any frame without a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_prev_r <= 1'b1;
            phase_r     <= PH_IDLE;
            cnt_r       <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            bad_r       <= 1'b0;
            rx_data_r   <= '0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            state_r     <= SW'(STATE_IDLE);
        end else begin
            line_prev_r <= line_s;
            phase_r     <= phase_s;
            cnt_r       <= cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            bad_r       <= bad_s;
            rx_data_r   <= rx_data_s;
            valid_r     <= valid_s;
            err_r       <= err_s;
            state_r     <= state_s;
        end
    end

    assign bus.received_data = rx_data_r;
    assign bus.data_is_valid = valid_r;
    assign bus.rx_error      = err_r;
    assign bus.state         = state_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed corner frames plus randomized frames against a frame-level model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int W       = 8;
    localparam int PE      = 1;
    localparam int PT      = 0;
    localparam int C       = 8;
    localparam int NB      = W + PE + 2;
    localparam int LATENCY = 3 + C / 2 + (NB - 1) * C + 1;
`ifdef UART_RX_FRAMING_ERROR_EN
    localparam bit FRAMING = 1'b1;
`else
    localparam bit FRAMING = 1'b0;
`endif

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if #(.DATA_WIDTH(W)) bus ();

    uart_rx #(
        .INPUT_DATA_WIDTH (W),
        .PARITY_ENABLED   (PE),
        .PARITY_TYPE      (PT),
        .CLOCKS_PER_BIT   (C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           last_valid_cyc = -1;
    int           t0 = 0;
    exp_t         exp_q[$];
    logic [W-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Frame-level reference: count ones for parity, then optional stop-bit rule.
    function automatic exp_t model(input logic [W-1:0] d, input logic par, input logic stp);
        exp_t e;
        int   ones;
        ones     = $countones(d) + ((PE != 0) ? int'(par) : 0) + PT;
        e.is_err = !(((ones % 2) == 0) && (stp || !FRAMING));
        e.data   = d;
        return e;
    endfunction

    task automatic drive_bit(input logic b);
        bus.serial_in = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stp);
        exp_q.push_back(model(d, par, stp));
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (PE != 0) drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pop one expectation per output pulse and track the value that must be held.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.data_is_valid || bus.rx_error) begin
                check("pulse_exclusive", 32'(bus.data_is_valid & bus.rx_error), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({bus.data_is_valid, bus.rx_error}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_is_error", 32'(bus.rx_error), 32'(e.is_err));
                    if (!e.is_err) begin
                        check("received_data", 32'(bus.received_data), 32'(e.data));
                        held           = e.data;
                        last_valid_cyc = cyc;
                    end
                end
            end
            if (!bus.data_is_valid) check("data_hold", 32'(bus.received_data), 32'(held));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(bus.state), 32'(STATE_IDLE));
        check("reset_valid", 32'(bus.data_is_valid), 32'd0);
        check("reset_error", 32'(bus.rx_error), 32'd0);
        check("reset_data", 32'(bus.received_data), 32'd0);
        reset = 1'b1;
        repeat (C) @(negedge clk);

        // Good 0xA5 frame and its latency from the first low sample
        t0 = cyc + 1;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_drain(3 * C);
        check("latency", 32'(last_valid_cyc - t0), 32'(LATENCY));
        check("idle_after_frame", 32'(bus.state), 32'(STATE_IDLE));

        // Wrong parity: error pulse, payload keeps 0xA5
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_drain(3 * C);
        check("data_kept_after_error", 32'(bus.received_data), 32'hA5);
        repeat (C) @(negedge clk);

        // Two-cycle glitch: enters START, then falls back to IDLE silently
        bus.serial_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_enters_start", 32'(bus.state), 32'(STATE_START));
        repeat (2 * C) @(negedge clk);
        check("glitch_back_idle", 32'(bus.state), 32'(STATE_IDLE));

        // Reset during DATA_3, then a clean 0x3C frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        for (int i = 0; i < 3 * C && bus.state != 4'(STATE_DATA_BASE + 3); i++) @(negedge clk);
        check("reached_data3", 32'(bus.state), 32'(STATE_DATA_BASE + 3));
        #2;
        reset         = 1'b0;
        held          = '0;
        bus.serial_in = 1'b1;
        #1;
        check("abort_state", 32'(bus.state), 32'(STATE_IDLE));
        check("abort_valid", 32'(bus.data_is_valid), 32'd0);
        check("abort_error", 32'(bus.rx_error), 32'd0);
        check("abort_data", 32'(bus.received_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (C) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_drain(3 * C);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_drain(3 * C);
        repeat (C) @(negedge clk);

        // Stop bit low on 0x55; line stays low and must not re-arm
        send_frame(8'h55, 1'b0, 1'b0);
        wait_drain(3 * C);
        repeat (3 * C) @(negedge clk);
        check("no_rearm_while_low", 32'(bus.state), 32'(STATE_IDLE));
        bus.serial_in = 1'b1;
        repeat (C) @(negedge clk);

        // Randomized frames: random payload, occasional bad parity / low stop, random gaps
        for (int f = 0; f < 24; f++) begin
            logic [W-1:0] d;
            logic         par;
            logic         stp;
            d   = W'($urandom);
            par = (^d) ^ 1'(PT);
            if ($urandom_range(0, 3) == 0) par = ~par;
            stp = ($urandom_range(0, 5) != 0);
            send_frame(d, par, stp);
            if (!stp) begin
                repeat (C) @(negedge clk);
                bus.serial_in = 1'b1;
                repeat (C) @(negedge clk);
            end
            repeat ($urandom_range(0, 2) * C) @(negedge clk);
        end
        wait_drain(4 * C);
        check("final_idle", 32'(bus.state), 32'(STATE_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have parameter PARITY_ENABLED, default 1: 1 = frame carries a parity bit, 0 = no parity bit.
REQ-003 SHALL have parameter PARITY_TYPE, default 0: 0 = even parity, 1 = odd parity.
REQ-004 SHALL have parameter CLOCKS_PER_BIT, default 8: clk cycles per bit, even, at least 4.
REQ-005 SHALL have port clk  input  1  sole clock; one clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset is asynchronous and active-low.
REQ-007 SHALL have port serial_in  input  1  asynchronous line input, idle high.
REQ-008 SHALL have port received_data  output  INPUT_DATA_WIDTH  last good frame payload, LSB first on the line.
REQ-009 SHALL have port data_is_valid  output  1  one-cycle pulse; received_data is new and good.
REQ-010 SHALL have port rx_error  output  1  one-cycle pulse; frame rejected.
REQ-011 SHALL have port state  output  clog2(INPUT_DATA_WIDTH+3)  current FSM state, for observability.

Function
REQ-012 SHALL pass serial_in through 3 flip-flops before any use, and all decisions SHALL use the synchronized line only.
REQ-013 SHALL use state encoding IDLE=0, START=1, DATA_k=2+k (k=0..INPUT_DATA_WIDTH-1), PARITY=INPUT_DATA_WIDTH+2, STOP=INPUT_DATA_WIDTH+3.
REQ-014 SHALL leave IDLE for START on a synchronized high-to-low transition, and SHALL clear the bit counter at that transition.
REQ-015 SHALL re-sample in START after CLOCKS_PER_BIT/2 cycles: low -> DATA_0; high -> IDLE, as a glitch with no pulse on any output.
REQ-016 SHALL sample each later bit exactly CLOCKS_PER_BIT cycles after the previous sample, storing data bits LSB first.
REQ-017 SHALL go from DATA_(W-1) to PARITY when PARITY_ENABLED=1, and to STOP otherwise.
REQ-018 SHALL check in PARITY that the XOR of the data bits, the sampled parity bit and PARITY_TYPE equals 0, and SHALL mark the frame bad on mismatch.
REQ-019 SHALL evaluate the frame on the STOP sample: a good frame drives data_is_valid=1 for exactly one cycle, with received_data updated in that same cycle.
REQ-020 SHALL, on a bad frame, drive rx_error=1 for one cycle, leave data_is_valid=0 and hold received_data unchanged.
REQ-021 SHALL never assert data_is_valid and rx_error in the same cycle.
REQ-022 SHALL return to IDLE in the cycle after the STOP sample, so a start edge arriving immediately after the stop bit is accepted.
REQ-023 SHALL NOT re-arm from IDLE after a stop bit sampled low until the synchronized line has been high for at least one cycle.
REQ-024 SHALL assert data_is_valid 3 + CLOCKS_PER_BIT/2 + (NB-1)*CLOCKS_PER_BIT + 1 cycles after the first clk edge that samples serial_in low, where NB = INPUT_DATA_WIDTH + PARITY_ENABLED + 2 (88 cycles at defaults).
REQ-025 SHALL hold received_data stable between data_is_valid pulses.

Reset
REQ-026 SHALL, while reset is low, set state=IDLE, all synchronizer flops=1, received_data=0, data_is_valid=0, rx_error=0 and counters=0.
REQ-027 SHALL abandon any frame in progress when reset is asserted, with no pulse on any output; after release, reception restarts only on a fresh start edge.

Configuration
REQ-028 SHALL check the stop bit when UART_RX_FRAMING_ERROR_EN is defined: a low STOP sample makes the frame bad (REQ-020), independent of parity.
REQ-029 SHALL NOT check the STOP sample level when UART_RX_FRAMING_ERROR_EN is undefined; frame goodness then depends on parity only, and REQ-023 still applies.

Structure
REQ-030 SHALL take the state encoding localparams and NUMBER_OF_RX_SYNCHRONIZERS=3 from shared package uart_pkg, which the transmitter also uses.
REQ-031 SHALL implement the 3-FF synchronizer as sub-module uart_rx_synchronizer, whose reset value is 1.

Verification
REQ-032 SHALL cover: defaults, frame 0xA5 with parity 0 and stop 1 -> data_is_valid at cycle 88, received_data=0xA5, rx_error=0.
REQ-033 SHALL cover: 0xA5 with parity bit driven 1 -> rx_error pulse once, data_is_valid stays 0, received_data keeps its prior value.
REQ-034 SHALL cover: serial_in low for 2 cycles, then high -> state returns to 0 and neither output pulses.
REQ-035 SHALL cover: reset asserted during DATA_3 -> state=0 and outputs 0 immediately; a following 0x3C frame is received correctly.
REQ-036 SHALL cover: back-to-back 0x00 then 0xFF with no idle gap -> two data_is_valid pulses, values 0x00 then 0xFF.
REQ-037 SHALL cover: stop bit driven 0 on 0x55 -> rx_error with UART_RX_FRAMING_ERROR_EN defined, data_is_valid with 0x55 without it; in both cases no re-arm until the line is high.
